// File: rtl/push_btn_interface.sv
`timescale 1ns/1ps
// push_btn_interface
//   Conditions one raw mechanical push-button for synchronous logic:
//   two-flop synchroniser, stability-counter debounce, and a one-cycle
//   pulse on every debounced press.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive synchronised cycles the input must differ
//                     from the debounced state before that state flips (>= 1)
//
// Ports
//   clock           : system clock, rising-edge active
//   reset           : asynchronous, active-low reset
//   button          : raw button level, asynchronous to clock (1 = pressed)
//   button_pressed  : registered, high for one cycle per debounced press
//   button_released : registered, high for one cycle per debounced release
//                     (present only when PUSHBTN_RELEASE_PULSE_EN is defined)
//
// Optional feature macro: PUSHBTN_RELEASE_PULSE_EN
module push_btn_interface #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
`ifdef PUSHBTN_RELEASE_PULSE_EN
  output logic button_released,
`endif
  output logic button_pressed
);

  localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Debounced button state; encoding matches the synchronised level.
  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } state_t;

  logic                 sync_meta;
  logic                 sync_s;
  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 pressed_next;
`ifdef PUSHBTN_RELEASE_PULSE_EN
  logic                 released_next;
`endif

  // Two-flop synchroniser; only sync_s is used downstream.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= button;
      sync_s    <= sync_meta;
    end
  end

  // Debounce state, counter and output pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_UP;
      cnt            <= '0;
      button_pressed <= 1'b0;
`ifdef PUSHBTN_RELEASE_PULSE_EN
      button_released <= 1'b0;
`endif
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      button_pressed <= pressed_next;
`ifdef PUSHBTN_RELEASE_PULSE_EN
      button_released <= released_next;
`endif
    end
  end

  // Next state: count cycles of disagreement, flip on the last one.
  // Any agreement clears the count, so bounce restarts the window.
  always_comb begin
    state_next   = state;
    cnt_next     = '0;
    pressed_next = 1'b0;
`ifdef PUSHBTN_RELEASE_PULSE_EN
    released_next = 1'b0;
`endif
    if (sync_s != logic'(state)) begin
      if (cnt == CNT_LAST) begin
        state_next   = state_t'(sync_s);
        pressed_next = sync_s;
`ifdef PUSHBTN_RELEASE_PULSE_EN
        released_next = !sync_s;
`endif
      end else begin
        cnt_next = cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_push_btn_interface.sv
`timescale 1ns/1ps
// Testbench for push_btn_interface: directed scenarios plus random
// segments, checked every cycle against a sliding-window reference model.
module tb_push_btn_interface;

  localparam int unsigned DEB = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic button = 1'b0;
  logic button_pressed;
`ifdef PUSHBTN_RELEASE_PULSE_EN
  logic button_released;
`endif

  push_btn_interface #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock          (clock),
    .reset          (reset),
    .button         (button),
`ifdef PUSHBTN_RELEASE_PULSE_EN
    .button_released(button_released),
`endif
    .button_pressed (button_pressed)
  );

  always #2 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: button samples per edge, and the synchronised level
  // seen at each edge (button from two edges earlier).
  logic bhist[$];
  logic svals[$];
  logic m_db = 1'b0;

  int pulses_p, pulses_r, seg_step, first_p, first_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    bhist.delete();
    svals.delete();
    m_db = 1'b0;
  endtask

  task automatic begin_scn();
    pulses_p = 0;
    pulses_r = 0;
    seg_step = 0;
    first_p  = -1;
    first_r  = -1;
  endtask

  // One clock with the given button level; model predicts, then compare.
  task automatic step(input logic b);
    logic s_now;
    logic flip;
    logic exp_p;
    logic exp_r;
    button = b;
    @(posedge clock);
    bhist.push_back(b);
    s_now = (bhist.size() >= 3) ? bhist[bhist.size()-3] : 1'b0;
    while (bhist.size() > 3) void'(bhist.pop_front());
    svals.push_back(s_now);
    while (svals.size() > DEB) void'(svals.pop_front());
    // Flip when the last DEB synchronised levels all disagree with state.
    flip = (svals.size() == DEB);
    for (int i = 0; i < int'(DEB); i++)
      if (flip && svals[i] == m_db) flip = 1'b0;
    exp_p = 1'b0;
    exp_r = 1'b0;
    if (flip) begin
      m_db  = ~m_db;
      exp_p = m_db;
      exp_r = ~m_db;
    end
    #1;
    seg_step++;
    check("pressed", 32'(button_pressed), 32'(exp_p));
    if (button_pressed === 1'b1) begin
      pulses_p++;
      if (first_p < 0) first_p = seg_step;
    end
`ifdef PUSHBTN_RELEASE_PULSE_EN
    check("released", 32'(button_released), 32'(exp_r));
    check("no_overlap", 32'(button_pressed & button_released), 32'd0);
    if (button_released === 1'b1) begin
      pulses_r++;
      if (first_r < 0) first_r = seg_step;
    end
`endif
  endtask

  task automatic run_seg(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  // Assert reset between edges, hold for some edges, release between edges.
  task automatic do_reset(input int cycles);
    reset = 1'b0;
    #1;
    check("rst_pressed_now", 32'(button_pressed), 32'd0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      check("rst_pressed_hold", 32'(button_pressed), 32'd0);
`ifdef PUSHBTN_RELEASE_PULSE_EN
      check("rst_released_hold", 32'(button_released), 32'd0);
`endif
    end
    reset = 1'b1;
    model_clear();
  endtask

  initial begin
    begin_scn();
    // Power-on reset
    repeat (3) @(posedge clock);
    #1;
    check("reset_pressed", 32'(button_pressed), 32'd0);
`ifdef PUSHBTN_RELEASE_PULSE_EN
    check("reset_released", 32'(button_released), 32'd0);
`endif
    reset = 1'b1;
    model_clear();

    // Press held 12 cycles then released: one pulse at E(DEB+1)
    begin_scn();
    run_seg(1'b1, 12);
    run_seg(1'b0, 12);
    check("s1_pulses", 32'(pulses_p), 32'd1);
    check("s1_latency", 32'(first_p), 32'(DEB + 2));
`ifdef PUSHBTN_RELEASE_PULSE_EN
    check("s1_rel_pulses", 32'(pulses_r), 32'd1);
    check("s1_rel_latency", 32'(first_r), 32'(12 + DEB + 2));
`endif

    // Short press of 2 cycles ignored
    begin_scn();
    run_seg(1'b1, 2);
    run_seg(1'b0, 10);
    check("s2_pulses", 32'(pulses_p), 32'd0);

    // Bounce burst ignored
    begin_scn();
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      step(1'b0);
    end
    run_seg(1'b0, 10);
    check("s3_pulses", 32'(pulses_p), 32'd0);

    // Boundary: DEB-1 cycles ignored, exactly DEB cycles accepted
    begin_scn();
    run_seg(1'b1, int'(DEB) - 1);
    run_seg(1'b0, 12);
    check("s_short_pulses", 32'(pulses_p), 32'd0);
    begin_scn();
    run_seg(1'b1, int'(DEB));
    run_seg(1'b0, 12);
    check("s_exact_pulses", 32'(pulses_p), 32'd1);

    // Long gap re-press: two pulses
    begin_scn();
    run_seg(1'b1, 25);
    run_seg(1'b0, 12);
    run_seg(1'b1, 12);
    run_seg(1'b0, 12);
    check("s4a_pulses", 32'(pulses_p), 32'd2);

    // Short gap: no debounced release, so one pulse only
    begin_scn();
    run_seg(1'b1, 25);
    run_seg(1'b0, 4);
    run_seg(1'b1, 12);
    run_seg(1'b0, 12);
    check("s4b_pulses", 32'(pulses_p), 32'd1);

    // Reset 5 cycles into a held press; button stays high afterwards
    begin_scn();
    run_seg(1'b1, 5);
    button = 1'b1;
    do_reset(2);
    begin_scn();
    run_seg(1'b1, 15);
    run_seg(1'b0, 12);
    check("s5_pulses", 32'(pulses_p), 32'd1);
    check("s5_latency", 32'(first_p), 32'(DEB + 2));

    // Reset while a press pulse is in flight
    begin_scn();
    run_seg(1'b1, int'(DEB) + 2);
    check("s6_pulse_seen", 32'(button_pressed), 32'd1);
    do_reset(1);
    run_seg(1'b0, 12);

    // Random segments with occasional resets
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 39) == 0) do_reset(int'($urandom_range(1, 3)));
      run_seg(1'($urandom()), int'($urandom_range(1, 12)));
    end
    run_seg(1'b0, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/push_btn_interface.md
Name: push_btn_interface

Overview:
- Conditions one raw mechanical push-button input for synchronous logic.
- Synchronises the asynchronous button level into the clock domain and debounces it with a stability counter.
- Emits a single-clock-cycle pulse on each debounced press.
- Sits between the board pin and any control logic that consumes discrete button events.

Parameters:
- DEBOUNCE_CYCLES, 8, consecutive clock cycles the synchronised input must differ from the debounced state before that state flips. Legal range is 1 or more.
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES+1), width of the debounce counter. It is derived and not overridden.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- button  input  1  raw button level, asynchronous to clock; 1 = pressed.
- button_pressed  output  1  registered; high for exactly one cycle per debounced press.

Behaviour:
- Single clock domain; one asynchronous, active-low reset.
- Reset (reset low), asynchronous:
  - Both synchroniser flops = 0, debounced state = 0, counter = 0.
  - button_pressed = 0.
  - With the optional feature, button_released = 0.
  - Outputs stay 0 while reset is held.
- Synchroniser:
  - Two-flop chain on button; s denotes the output of the second flop.
  - Nothing downstream samples button directly.
- Debounce counter, evaluated each rising edge:
  - If s equals the debounced state, the counter clears to 0.
  - If s differs and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If s differs and counter = DEBOUNCE_CYCLES-1, the debounced state takes s and the counter clears to 0.
  - The counter never wraps; a flip always clears it.
- Press pulse:
  - button_pressed is set to 1 at the same edge the debounced state flips 0->1.
  - It is cleared at the next edge.
  - A 1->0 flip never asserts button_pressed.
- Latency: let E0 be the first edge at which button is sampled high. s goes high after E1. The pulse is visible from edge E(DEBOUNCE_CYCLES+1) and lasts one cycle. The default gives 9 edges.
- Filtering: any level held for fewer than DEBOUNCE_CYCLES consecutive synchronised cycles is ignored. Bounce resets the count on every reversal.
- Holding: a press held indefinitely yields exactly one pulse; there is no auto-repeat.
- Re-press: requires a debounced release first, i.e. low for DEBOUNCE_CYCLES cycles.
- Button high at reset deassertion: the debounced state starts at 0, so a press pulse is produced DEBOUNCE_CYCLES+2 edges after release of reset.
- Reset mid-operation: any partial count is discarded. An in-flight pulse is cleared immediately.

Optional Feature:
- Macro: PUSHBTN_RELEASE_PULSE_EN.
- When defined:
  - Adds output port button_released (output, 1 bit, registered).
  - It pulses high for exactly one cycle at the edge the debounced state flips 1->0.
  - Same latency as press and same reset value 0.
  - button_pressed and button_released are never high in the same cycle.
- When undefined:
  - The port and its logic are absent.
  - Release transitions produce no output.

Test Plan (4 ns clock, DEBOUNCE_CYCLES=8, reset pulsed low at start):
- Hold button high for 12 cycles after reset, then low -> exactly one button_pressed pulse, one cycle wide, at 9th edge after first sampling edge; no pulse on release.
- Hold button high for only 2 cycles -> button_pressed stays 0 throughout; counter returns to 0.
- Bounce burst, 1 cycle high / 1 cycle low repeated 6 times, then low -> no pulse.
- Hold high 25 cycles, low 12 cycles, high 12 cycles -> exactly two pulses, each one cycle wide. Repeat with the low gap shortened to 4 cycles -> exactly one pulse.
- Assert reset low for 2 cycles, 5 cycles into a held press -> button_pressed 0 during reset. One pulse arrives DEBOUNCE_CYCLES+2 edges after reset release if the button stays high.
- With PUSHBTN_RELEASE_PULSE_EN: press held 12 cycles then released -> one button_pressed pulse, then one button_released pulse 9 edges after release is first sampled; never coincident.
